// File: rtl/control_unit.sv
// Main opcode decoder for a single-issue RV32I core.
// Combinational decode of the 7-bit opcode, registered with one cycle of latency.
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  output logic       Regwrite,
  output logic       ALUsrc,
  output logic       Memread,
  output logic       Memwrite,
  output logic       Memtoreg,
  output logic       Branch,
  output logic       Jump,
  output logic [1:0] ALUop,
  output logic       illegal
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_RTYP = 2'b10,
    ALU_ITYP = 2'b11
  } aluop_e;

  typedef struct packed {
    logic   regwrite;
    logic   alusrc;
    logic   memread;
    logic   memwrite;
    logic   memtoreg;
    logic   branch;
    logic   jump;
    aluop_e aluop;
    logic   illegal;
  } ctrl_t;

  ctrl_t dec;
  ctrl_t ctrl_q;

  // All 7 bits are compared, so any value outside the table is illegal.
  always_comb begin
    dec = '0;
    case (opcode)
      OP_R: begin
        dec.regwrite = 1'b1;
        dec.aluop    = ALU_RTYP;
      end
      OP_I: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.aluop    = ALU_ITYP;
      end
      OP_LOAD: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.aluop    = ALU_ADD;
      end
      OP_STORE: begin
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
        dec.aluop    = ALU_ADD;
      end
      OP_BRANCH: begin
        dec.branch   = 1'b1;
        dec.aluop    = ALU_SUB;
      end
      OP_JAL: begin
        dec.regwrite = 1'b1;
        dec.jump     = 1'b1;
        dec.aluop    = ALU_ADD;
      end
      OP_JALR: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.jump     = 1'b1;
        dec.aluop    = ALU_ADD;
      end
      default: begin
        dec.illegal  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= dec;
    end
  end

  assign Regwrite = ctrl_q.regwrite;
  assign ALUsrc   = ctrl_q.alusrc;
  assign Memread  = ctrl_q.memread;
  assign Memwrite = ctrl_q.memwrite;
  assign Memtoreg = ctrl_q.memtoreg;
  assign Branch   = ctrl_q.branch;
  assign Jump     = ctrl_q.jump;
  assign ALUop    = ctrl_q.aluop;
  assign illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: reset, legal/illegal decode, latency, hold and invariants.
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       Regwrite, ALUsrc, Memread, Memwrite, Memtoreg, Branch, Jump, illegal;
  logic [1:0] ALUop;
  logic [9:0] obs;

  int total = 0;
  int bad   = 0;

  // Hand-computed rows: Regwrite ALUsrc Memread Memwrite Memtoreg Branch Jump ALUop illegal
  localparam logic [9:0] E_R    = 10'b1000000_10_0;
  localparam logic [9:0] E_I    = 10'b1100000_11_0;
  localparam logic [9:0] E_LD   = 10'b1110100_00_0;
  localparam logic [9:0] E_ST   = 10'b0101000_00_0;
  localparam logic [9:0] E_BR   = 10'b0000010_01_0;
  localparam logic [9:0] E_JAL  = 10'b1000001_00_0;
  localparam logic [9:0] E_JALR = 10'b1100001_00_0;
  localparam logic [9:0] E_ILL  = 10'b0000000_00_1;
  localparam logic [9:0] E_ZERO = 10'b0;

  control_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .Regwrite (Regwrite),
    .ALUsrc   (ALUsrc),
    .Memread  (Memread),
    .Memwrite (Memwrite),
    .Memtoreg (Memtoreg),
    .Branch   (Branch),
    .Jump     (Jump),
    .ALUop    (ALUop),
    .illegal  (illegal)
  );

  assign obs = {Regwrite, ALUsrc, Memread, Memwrite, Memtoreg, Branch, Jump, ALUop, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] model(input logic [6:0] op);
    case (op)
      7'b0110011: return E_R;
      7'b0010011: return E_I;
      7'b0000011: return E_LD;
      7'b0100011: return E_ST;
      7'b1100011: return E_BR;
      7'b1101111: return E_JAL;
      7'b1100111: return E_JALR;
      default:    return E_ILL;
    endcase
  endfunction

  task automatic check(input string tag, input logic [9:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_inv(input string tag);
    total++;
    assert (!(Memread && Memwrite) && !(Branch && Jump) && !(illegal && (obs[9:1] != 9'b0)))
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=invariants_hold", tag, obs);
    end
  endtask

  // Apply op, then sample 1 time unit after the capturing edge.
  task automatic step(input logic [6:0] op);
    opcode = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] legal [7];
    logic [6:0] r;
    legal = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
              7'b1100011, 7'b1101111, 7'b1100111};

    rst_n  = 1'b0;
    opcode = 7'b0110011;
    #1;
    check("reset_initial", E_ZERO);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_held", E_ZERO);
    end

    // Release reset, decode a load, then assert reset mid-cycle.
    rst_n = 1'b1;
    step(7'b0000011);
    check("load_after_reset", E_LD);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear_midcycle", E_ZERO);
    opcode = 7'b0110011;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_after_release", E_R);

    // Legal sweep, also confirming the previous row holds before each edge.
    check("sweep_pre", E_R);
    step(legal[0]); check("sweep_r", E_R);
    opcode = legal[1]; #2; check("sweep_hold_r", E_R);
    step(legal[1]); check("sweep_i", E_I);
    opcode = legal[2]; #2; check("sweep_hold_i", E_I);
    step(legal[2]); check("sweep_load", E_LD);
    step(legal[3]); check("sweep_store", E_ST);
    step(legal[4]); check("sweep_branch", E_BR);
    step(legal[5]); check("sweep_jal", E_JAL);
    step(legal[6]); check("sweep_jalr", E_JALR);

    // Illegal opcodes, including wrong low bits.
    step(7'b1111111); check("illegal_ones", E_ILL);
    step(7'b0000000); check("illegal_zero", E_ILL);
    step(7'b0110010); check("illegal_rflip0", E_ILL);
    step(7'b0110001); check("illegal_rflip1", E_ILL);
    step(7'b1110011); check("illegal_system", E_ILL);

    // Store then load on adjacent edges.
    step(7'b0100011); check("b2b_store", E_ST); check_inv("b2b_store_inv");
    step(7'b0000011); check("b2b_load", E_LD);  check_inv("b2b_load_inv");
    step(7'b0110011); check("b2b_after", E_R);

    // Hold JAL for 4 cycles, then change opcode between edges.
    for (int i = 0; i < 4; i++) begin
      step(7'b1101111);
      check("hold_jal", E_JAL);
    end
    #2;
    opcode = 7'b1100011;
    #1;
    check("between_edges_no_change", E_JAL);
    @(posedge clk);
    #1;
    check("between_edges_after_edge", E_BR);

    // Random opcodes, biased toward legal ones.
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(1, 0) == 0)
        r = legal[$urandom_range(6, 0)];
      else
        r = 7'($urandom);
      step(r);
      check("random_decode", model(r));
      check_inv("random_inv");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main decoder of a single-issue RV32I core; sits between instruction fetch/decode and the datapath.
- Decodes the 7-bit instruction opcode into datapath control strobes: register write, ALU operand select, memory read/write, writeback select, branch, jump and 2-bit ALU operation class.
- Outputs are registered: one clock of latency, asynchronously cleared by reset.

Parameters:
- none (opcode width fixed at 7, ALUop width fixed at 2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  7  instruction bits [6:0]
- Regwrite  output  1  write result to register file
- ALUsrc  output  1  1 = ALU operand B is the immediate, 0 = rs2
- Memread  output  1  data-memory read enable
- Memwrite  output  1  data-memory write enable
- Memtoreg  output  1  1 = writeback from memory, 0 = from ALU/PC+4 path
- Branch  output  1  conditional-branch instruction
- Jump  output  1  unconditional jump (JAL/JALR)
- ALUop  output  2  ALU operation class for the ALU decoder
- illegal  output  1  opcode not in the supported set

Behaviour:
- Reset: rst_n low asynchronously forces every output to 0, including ALUop=00 and illegal=0. Outputs stay 0 while rst_n is low.
- Operation: on each rising clk edge with rst_n high, all outputs load the decode of the opcode present at that edge.
  - Latency is exactly 1 cycle.
  - Outputs hold between edges, with no glitching.
- Decode table (bit order Regwrite ALUsrc Memread Memwrite Memtoreg Branch Jump ALUop illegal):
  - 0110011 R-type: 1 0 0 0 0 0 0 10 0
  - 0010011 I-type ALU: 1 1 0 0 0 0 0 11 0
  - 0000011 Load: 1 1 1 0 1 0 0 00 0
  - 0100011 Store: 0 1 0 1 0 0 0 00 0
  - 1100011 Branch: 0 0 0 0 0 1 0 01 0
  - 1101111 JAL: 1 0 0 0 0 0 1 00 0
  - 1100111 JALR: 1 1 0 0 0 0 1 00 0
  - any other value: 0 0 0 0 0 0 0 00 1
- ALUop encoding:
  - 00 = add (address/link calculation)
  - 01 = subtract/compare (branch)
  - 10 = R-type, use funct3/funct7
  - 11 = I-type, use funct3 only, except shifts
- Invariants, every cycle:
  - Memread and Memwrite are never both 1.
  - Branch and Jump are never both 1.
  - illegal=1 implies all other outputs are 0.
- Full 7-bit compare: opcodes differing from a legal one in any bit, including bits [1:0] != 11, decode as illegal.
- Reset released mid-stream: the first edge after rst_n rises loads the current opcode's decode; no stale state.
- Reset asserted between edges clears outputs immediately, without waiting for clk.

Test Plan:
- Reset: hold rst_n=0 with opcode=0110011 and clock for 3 cycles -> all outputs 0. Assert rst_n=0 mid-cycle after a Load decode -> outputs clear before the next edge.
- Legal sweep: apply each of the 7 legal opcodes on consecutive cycles -> each decode row above appears exactly one cycle after its opcode. Example: Load -> 1 1 1 0 1 0 0 00 0; Branch -> 0 0 0 0 0 1 0 01 0.
- Illegal: opcode=1111111 and 0000000 -> all strobes 0, ALUop=00, illegal=1. Then a single-bit flip of R-type, 0110010 -> illegal=1.
- Back-to-back: Store followed by Load on adjacent edges -> Memwrite=1 for exactly one cycle, then Memread=1 and Memtoreg=1 the next cycle; never both Memread and Memwrite set.
- Hold: keep opcode=1101111 for 4 cycles -> Jump=1 and Regwrite=1 held steady. Change opcode between edges -> outputs do not change until the next rising edge.
- Invariant check: random opcodes for 1000 cycles -> Memread&Memwrite=0, Branch&Jump=0, and illegal implies all other outputs 0, on every cycle.
